// File: rtl/microc_pkg.sv
// Shared opcode, state and ALU encodings for the microc control unit.
package microc_pkg;

  localparam logic [5:0] OP_LI   = 6'b000000;  // 0000xx
  localparam logic       OP_ALU  = 1'b1;       // opcode[5] prefix
  localparam logic [5:0] OP_J    = 6'b010000;
  localparam logic [5:0] OP_JZ   = 6'b010001;
  localparam logic [5:0] OP_JNZ  = 6'b010010;
  localparam logic [5:0] OP_JC   = 6'b010011;
  localparam logic [5:0] OP_JAL  = 6'b010100;
  localparam logic [5:0] OP_RET  = 6'b010101;
  localparam logic [5:0] OP_HALT = 6'b011111;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  function automatic logic is_alu(input logic [5:0] op);
    return op[5] == OP_ALU;
  endfunction

  function automatic logic is_li(input logic [5:0] op);
    return op[5:2] == OP_LI[5:2];
  endfunction

endpackage

// File: rtl/microc_ctrl_stack_ret_stack.sv
// Return-address stack; illegal push (full) or pop (empty) is ignored.
module ret_stack #(
  parameter int AW    = 10,
  parameter int DEPTH = 4,
  localparam int SPW  = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [AW-1:0]  din,
  output logic [AW-1:0]  top,
  output logic           full,
  output logic           empty,
  output logic [SPW-1:0] sp
);

  logic [SPW-1:0]            sp_q, sp_d;
  logic [DEPTH-1:0][AW-1:0]  mem_q, mem_d;

  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);
  assign sp    = sp_q;

  // Next pointer and entry write; the entry at sp is written on a legal push.
  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (push && !full) begin
      sp_d = sp_q + SPW'(1);
      for (int i = 0; i < DEPTH; i++)
        if (sp_q == SPW'(i)) mem_d[i] = din;
    end else if (pop && !empty) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  // Top of stack is mem[sp-1], zero when empty.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sp_q == SPW'(i + 1)) top = mem_q[i];
  end

  // Pointer register; contents need no reset since sp gates every read.
  always_ff @(posedge clk) begin
    if (reset) sp_q <= '0;
    else       sp_q <= sp_d;
  end

  // Stack storage.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/microc_ctrl_stack.sv
// microc control unit: opcode decode, latched ALU flags, call/return stack,
// and sticky HALT/ERR states.
module microc_ctrl_stack
  import microc_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    opcode,
  input  logic          zero,
  input  logic          carry,
  input  logic [AW-1:0] pc_next,
  output logic          s_inc,
  output logic          s_inm,
  output logic          we,
  output logic [2:0]    alu_op,
  output logic          pc_en,
  output logic          s_ret,
  output logic [AW-1:0] ret_addr,
  output logic          halted,
  output logic          err
);

  localparam int SPW = $clog2(DEPTH + 1);

  state_e          state_q, state_d;
  logic            zero_q, zero_d, carry_q, carry_d;
  logic            push, pop, full, empty;
  logic [AW-1:0]   top;
  logic [SPW-1:0]  sp;

  ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_stk (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(pc_next),
    .top(top), .full(full), .empty(empty), .sp(sp)
  );

  // Decode: outputs and next state; everything quiet in reset, HALT and ERR.
  always_comb begin
    state_d = state_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    pc_en   = 1'b0;
    s_inc   = 1'b1;
    s_inm   = 1'b0;
    we      = 1'b0;
    s_ret   = 1'b0;
    alu_op  = ALU_NOP;
    push    = 1'b0;
    pop     = 1'b0;
    if (!reset && state_q == ST_RUN) begin
      pc_en = 1'b1;
      if (is_alu(opcode)) begin
        we      = 1'b1;
        alu_op  = opcode[4:2];
        zero_d  = zero;
        carry_d = carry;
      end else if (is_li(opcode)) begin
        we    = 1'b1;
        s_inm = 1'b1;
      end else begin
        case (opcode)
          OP_J:   s_inc = 1'b0;
          OP_JZ:  s_inc = ~zero_q;
          OP_JNZ: s_inc = zero_q;
          OP_JC:  s_inc = ~carry_q;
          OP_JAL: begin
            if (full) begin
              pc_en   = 1'b0;
              state_d = ST_ERR;
            end else begin
              push  = 1'b1;
              s_inc = 1'b0;
            end
          end
          OP_RET: begin
            if (empty) begin
              pc_en   = 1'b0;
              state_d = ST_ERR;
            end else begin
              pop   = 1'b1;
              s_ret = 1'b1;
              s_inc = 1'b0;
            end
          end
          OP_HALT: begin
            pc_en   = 1'b0;
            state_d = ST_HALT;
          end
          default: ;
        endcase
      end
    end
  end

  assign halted   = !reset && state_q == ST_HALT;
  assign err      = !reset && state_q == ST_ERR;
  assign ret_addr = reset ? '0 : top;

  // State and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_microc_ctrl_stack.sv
// Random + directed stimulus against a queue-based reference model.
module tb_microc_ctrl_stack;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic          zero, carry;
  logic [AW-1:0] pc_next;
  logic          s_inc, s_inm, we, pc_en, s_ret, halted, err;
  logic [2:0]    alu_op;
  logic [AW-1:0] ret_addr;

  microc_ctrl_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .carry(carry),
    .pc_next(pc_next), .s_inc(s_inc), .s_inm(s_inm), .we(we), .alu_op(alu_op),
    .pc_en(pc_en), .s_ret(s_ret), .ret_addr(ret_addr), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: mode 0=running, 1=halted, 2=error.
  int            m_mode = 0;
  bit            m_z = 0, m_c = 0;
  logic [AW-1:0] stk[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic z, input logic c,
                      input logic [AW-1:0] pn);
    logic          e_pc, e_inc, e_ret, e_we, e_inm, e_h, e_e, o_inc, o_ret;
    logic [2:0]    e_alu;
    logic [AW-1:0] e_ra;
    bit            mask;
    int            opv;
    reset = r; opcode = op; zero = z; carry = c; pc_next = pn;
    opv = int'(op);
    e_pc = 0; e_inc = 1; e_ret = 0; e_we = 0; e_inm = 0; e_alu = 0; mask = 0;
    e_h  = !r && m_mode == 1;
    e_e  = !r && m_mode == 2;
    e_ra = (r || stk.size() == 0) ? '0 : stk[$];
    if (!r && m_mode == 0) begin
      e_pc = 1;
      if (opv >= 32) begin
        e_we = 1; e_alu = 3'((opv - 32) / 4);
      end else if (opv < 4) begin
        e_we = 1; e_inm = 1;
      end else begin
        case (opv)
          16: e_inc = 0;
          17: e_inc = !m_z;
          18: e_inc = m_z;
          19: e_inc = !m_c;
          20: if (stk.size() == DEPTH) begin e_pc = 0; mask = 1; end else e_inc = 0;
          21: if (stk.size() == 0) begin e_pc = 0; mask = 1; end
              else begin e_ret = 1; e_inc = 0; end
          31: e_pc = 0;
          default: ;
        endcase
      end
    end
    @(negedge clk);
    o_inc = mask ? e_inc : s_inc;
    o_ret = mask ? e_ret : s_ret;
    chk("ctrl", {24'd0, pc_en, o_inc, o_ret, we, s_inm, alu_op},
                {24'd0, e_pc, e_inc, e_ret, e_we, e_inm, e_alu});
    chk("ret_addr", 32'(ret_addr), 32'(e_ra));
    chk("status", {30'd0, halted, err}, {30'd0, e_h, e_e});
    chk("sp", 32'(dut.u_stk.sp), stk.size());
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_z = 0; m_c = 0; stk.delete();
    end else if (m_mode == 0) begin
      if (opv >= 32) begin m_z = z; m_c = c; end
      else if (opv == 20) begin
        if (stk.size() == DEPTH) m_mode = 2; else stk.push_back(pn);
      end else if (opv == 21) begin
        if (stk.size() == 0) m_mode = 2; else void'(stk.pop_back());
      end else if (opv == 31) m_mode = 1;
    end
    #1;
  endtask

  function automatic logic [5:0] rand_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 15) return 6'($urandom_range(0, 3));
    if (r < 35) return 6'($urandom_range(32, 63));
    if (r < 43) return 6'd16;
    if (r < 51) return 6'd17;
    if (r < 59) return 6'd18;
    if (r < 66) return 6'd19;
    if (r < 79) return 6'd20;
    if (r < 92) return 6'd21;
    if (r < 94) return 6'd31;
    return 6'($urandom_range(4, 15));
  endfunction

  initial begin
    reset = 1; opcode = 0; zero = 0; carry = 0; pc_next = 0;
    #1;
    step(1, 6'd0, 0, 0, 0);
    // Reset mid-call, then RET underflows.
    step(0, 6'd20, 0, 0, 10'h100);
    step(0, 6'd20, 0, 0, 10'h101);
    step(1, 6'd0, 0, 0, 0);
    step(0, 6'd21, 0, 0, 0);
    step(0, 6'd0, 0, 0, 0);
    chk("err_after_underflow", {31'd0, err}, 32'd1);
    // LI, SUB zero=1, JZ / JNZ.
    step(1, 6'd0, 0, 0, 0);
    step(0, 6'd1, 0, 0, 0);
    step(0, 6'b101100, 1, 0, 0);
    step(0, 6'd17, 0, 0, 0);
    step(0, 6'd1, 0, 0, 0);
    step(0, 6'b101100, 1, 0, 0);
    step(0, 6'd18, 0, 0, 0);
    // Flag hold across LI.
    step(0, 6'b101000, 1, 0, 0);
    step(0, 6'd2, 0, 1, 0);
    step(0, 6'd17, 0, 0, 0);
    // Fill, drain, refill and overflow.
    for (int i = 1; i <= 4; i++) step(0, 6'd20, 0, 0, AW'(i * 'h11));
    for (int i = 0; i < 4; i++)  step(0, 6'd21, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 6'd20, 0, 0, AW'(i * 'h11));
    step(0, 6'd0, 0, 0, 0);
    chk("sp_after_overflow", 32'(dut.u_stk.sp), 32'd4);
    // HALT then ALU, then reset.
    step(1, 6'd0, 0, 0, 0);
    step(0, 6'd31, 0, 0, 0);
    step(0, 6'b100100, 1, 1, 0);
    step(1, 6'd0, 0, 0, 0);
    step(0, 6'd0, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 4, rand_op(), 1'($urandom), 1'($urandom),
           AW'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/microc_ctrl_stack.md
# microc_ctrl_stack

Parametrised control unit for the `microc` datapath. It decodes the 6-bit opcode into the datapath control lines (`s_inc`, `s_inm`, `we`, `alu_op`, plus the new `pc_en` and `s_ret`). Compared with the previous hand-driven control, it adds latched ALU flags for conditional jumps, a hardware return-address stack for call/return, and HALT/ERR states. It sits between the instruction memory opcode field and the datapath control inputs.

## Interface
- `AW`, 10, PC/address width (≥2)
- `DEPTH`, 4, return-stack entries (≥1)
- `clk  in  1  rising-edge clock`
- `reset  in  1  synchronous, active-high`
- `opcode  in  6  current instruction opcode`
- `zero  in  1  ALU zero result of current cycle`
- `carry  in  1  ALU carry result of current cycle`
- `pc_next  in  AW  PC+1 from datapath incrementer`
- `s_inc  out  1  1 = next PC is PC+1, 0 = jump target or return address`
- `s_inm  out  1  1 = register write data from immediate`
- `we  out  1  register-file write enable`
- `alu_op  out  3  ALU operation`
- `pc_en  out  1  PC register load enable`
- `s_ret  out  1  1 = next PC comes from `ret_addr``
- `ret_addr  out  AW  top of return stack`
- `halted  out  1  state is HALT`
- `err  out  1  state is ERR (stack overflow/underflow)`

## Operation
- States: RUN, HALT, ERR.
  - RUN→HALT on the HALT opcode.
  - RUN→ERR on a push when full or a pop when empty.
  - HALT and ERR are exit-only-by-reset.
- Decode in RUN. Defaults: `pc_en=1`, `s_inc=1`, `we=0`, `s_inm=0`, `s_ret=0`, `alu_op=000`.
  - `0000xx` LI: `we=1`, `s_inm=1`.
  - `1ooo xx` ALU: `we=1`, `alu_op=opcode[4:2]`. Latch `zero_q<=zero` and `carry_q<=carry`.
  - `010000` J: `s_inc=0`.
  - `010001` JZ: `s_inc=~zero_q`.
  - `010010` JNZ: `s_inc=zero_q`.
  - `010011` JC: `s_inc=~carry_q`.
  - `010100` JAL: push `pc_next`, `s_inc=0`.
  - `010101` RET: pop, `s_ret=1`, `s_inc=0`.
  - `011111` HALT: `pc_en=0`.
  - All other opcodes: NOP.
- Flags change only on ALU opcodes. Jumps, LI, JAL and RET leave the flags unchanged.
- Stack:
  - `sp` runs 0..DEPTH; full when `sp==DEPTH`, empty when `sp==0`.
  - Push writes `mem[sp]` and sets `sp+1`.
  - Pop sets `sp-1`.
  - `ret_addr=mem[sp-1]` when `sp>0`, else 0.
- Overflow/underflow: no stack change, `pc_en=0`, `we=0`, next state ERR.
- HALT/ERR outputs: `pc_en=0`, `we=0`, `s_inc=1`, `s_ret=0`, `alu_op=000`. No pushes, pops or flag updates.

## Timing
- Control outputs are combinational from `opcode`, state and flags, with zero-cycle latency. State, `sp`, stack and flags update on the rising `clk`.
- Reset (any cycle, including mid-call):
  - next edge sets state RUN, `sp=0`, `zero_q=0`, `carry_q=0`;
  - stack contents are don't-care.
- While `reset=1`: `we=0`, `pc_en=0`, `s_inc=1`, `s_ret=0`, `alu_op=000`, `halted=0`, `err=0`, `ret_addr=0`, and no push or pop occurs.
- A conditional jump in cycle n sees flags from the last ALU op at cycle ≤n-1. It never sees same-cycle `zero`/`carry`.
- RET directly after JAL returns the just-pushed `pc_next`.
- A push at `sp=DEPTH-1` succeeds and the stack becomes full. The next JAL goes to ERR.

## Structure
- Package `microc_pkg`:
  - opcode constants (OP_LI, OP_ALU prefix, OP_J, OP_JZ, OP_JNZ, OP_JC, OP_JAL, OP_RET, OP_HALT);
  - state encoding (RUN=2'd0, HALT=2'd1, ERR=2'd2);
  - ALU op codes (ADD=010, SUB=011).
- Sub-module `ret_stack` (parameters `AW`, `DEPTH`; inputs push/pop/din; outputs top/full/empty). It ignores an illegal push or pop itself.

## Test plan
- Reset mid-call: assert `reset` after two JALs → next cycle `sp=0`, RET immediately → ERR, `err=1`.
- LI then ALU SUB with `zero=1,carry=0`, then JZ → `s_inc=0`, `pc_en=1`. The same sequence with JNZ → `s_inc=1`.
- Flag hold: ADD with `zero=1`, then LI with datapath `zero=0`, then JZ → still `s_inc=0`.
- DEPTH=4:
  - JAL ×4 with `pc_next` 0x011, 0x022, 0x033, 0x044;
  - RET ×4 → `ret_addr` 0x044, 0x033, 0x022, 0x011, each with `s_ret=1`, `s_inc=0`.
- Overflow: 5th JAL → `pc_en=0`, `err=1` next cycle, and `sp` stays 4. Subsequent LI → `we=0`.
- HALT opcode → `pc_en=0` the same cycle, `halted=1` next cycle, and later ALU opcodes give `we=0`. `reset` → RUN with `halted=0`.
